// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scan driver for NUM_DIGITS common-anode digits.
// Frames are swapped only at the scan-frame boundary so a digit never tears mid-frame.
module seg_scan_mux #(
    parameter int NUM_DIGITS  = 8,
    parameter int SEG_W       = 7,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*SEG_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       blank_mask,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    input  logic [3:0]                  brightness,
    input  logic                        load,
    output logic [SEG_W-1:0]            displayout,
    output logic [NUM_DIGITS-1:0]       selector,
    output logic                        frame_done
);
    localparam int SW   = $clog2(REFRESH_DIV);
    localparam int DW   = $clog2(NUM_DIGITS);
    localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int CW   = SW + 1;
    localparam int UNIT = REFRESH_DIV / 16;

    logic [SW-1:0]         slot_cnt_reg;
    logic [DW-1:0]         digit_idx_reg;
    logic [BW-1:0]         blink_cnt_reg;
    logic                  blink_phase_reg;
    logic                  pending_valid_reg;
    logic [SEG_W-1:0]      active_pat_reg  [NUM_DIGITS];
    logic [SEG_W-1:0]      pending_pat_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_act_reg, blink_act_reg;
    logic [NUM_DIGITS-1:0] blank_pend_reg, blink_pend_reg;
    logic [NUM_DIGITS-1:0] selector_reg;
    logic [SEG_W-1:0]      displayout_reg;
    logic                  frame_done_reg;

    logic                  slot_last, digit_last, fb;
    logic [CW-1:0]         on_time;
    logic                  lit;
    logic [NUM_DIGITS-1:0] selector_next;
    logic [SEG_W-1:0]      displayout_next;

    assign slot_last  = (slot_cnt_reg == SW'(REFRESH_DIV - 1));
    assign digit_last = (digit_idx_reg == DW'(NUM_DIGITS - 1));
    assign fb         = slot_last && digit_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_reg    <= '0;
            digit_idx_reg   <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            if (slot_last) begin
                slot_cnt_reg  <= '0;
                digit_idx_reg <= digit_last ? '0 : digit_idx_reg + 1'b1;
            end else begin
                slot_cnt_reg  <= slot_cnt_reg + 1'b1;
            end
            if (fb) begin
                if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
                    blink_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    blink_cnt_reg   <= blink_cnt_reg + 1'b1;
                end
            end
        end
    end

    // A load coinciding with the boundary bypasses pending and goes straight to active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_valid_reg <= 1'b0;
            blank_pend_reg    <= '0;
            blink_pend_reg    <= '0;
            blank_act_reg     <= '0;
            blink_act_reg     <= '0;
        end else begin
            if (load) begin
                blank_pend_reg <= blank_mask;
                blink_pend_reg <= blink_mask;
            end
            if (fb) begin
                pending_valid_reg <= 1'b0;
                if (load) begin
                    blank_act_reg <= blank_mask;
                    blink_act_reg <= blink_mask;
                end else if (pending_valid_reg) begin
                    blank_act_reg <= blank_pend_reg;
                    blink_act_reg <= blink_pend_reg;
                end
            end else if (load) begin
                pending_valid_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pending_pat_reg[gi] <= '1;
                active_pat_reg[gi]  <= '1;
            end else begin
                if (load)
                    pending_pat_reg[gi] <= digits_in[gi*SEG_W +: SEG_W];
                if (fb && load)
                    active_pat_reg[gi] <= digits_in[gi*SEG_W +: SEG_W];
                else if (fb && pending_valid_reg)
                    active_pat_reg[gi] <= pending_pat_reg[gi];
            end
        end
        assign selector_next[gi] = !(lit && (digit_idx_reg == DW'(gi)));
    end

    // On-time is at most REFRESH_DIV, so one extra bit keeps the product exact.
    assign on_time = (CW'(brightness) + CW'(1)) * CW'(UNIT);

    always_comb begin
        lit = (slot_cnt_reg != '0)
              && ({1'b0, slot_cnt_reg} < on_time)
              && !blank_act_reg[digit_idx_reg]
              && !(blink_phase_reg && blink_act_reg[digit_idx_reg]);
        displayout_next = '1;
        if (lit)
            displayout_next = active_pat_reg[digit_idx_reg];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            selector_reg   <= '1;
            displayout_reg <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            selector_reg   <= selector_next;
            displayout_reg <= displayout_next;
            frame_done_reg <= fb;
        end
    end

    assign selector   = selector_reg;
    assign displayout = displayout_reg;
    assign frame_done = frame_done_reg;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: 4 digits, 32-cycle slots, 128-cycle frames, blink every 2 frames.
module tb_seg_scan_mux;
    localparam int ND = 4;
    localparam int SW = 7;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [ND*SW-1:0] digits_in = '0;
    logic [ND-1:0]  blank_mask = '0;
    logic [ND-1:0]  blink_mask = '0;
    logic [3:0]     brightness = 4'd15;
    logic           load = 1'b0;
    logic [SW-1:0]  displayout;
    logic [ND-1:0]  selector;
    logic           frame_done;

    seg_scan_mux #(.NUM_DIGITS(ND), .SEG_W(SW), .REFRESH_DIV(32), .BLINK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .brightness(brightness), .load(load),
        .displayout(displayout), .selector(selector), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pos;
        logic        ld;
        logic [27:0] data;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic [3:0]  bright;
        logic [3:0]  exp_sel;
        logic [6:0]  exp_disp;
        logic        exp_fd;
    } vec_t;

    localparam logic [27:0] PAT_A = {7'h30, 7'h24, 7'h79, 7'h40};
    localparam logic [27:0] PAT_B = {7'h11, 7'h12, 7'h13, 7'h14};
    localparam logic [27:0] PAT_C = {7'h01, 7'h02, 7'h03, 7'h08};
    localparam logic [27:0] PAT_D = {7'h4D, 7'h3B, 7'h2A, 7'h1C};
    localparam logic [27:0] PAT_E = 28'h0;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;   // outputs after step() reflect counter position cyc-1
    vec_t vecs[33];

    function automatic vec_t mkv(int pos, logic ld, logic [27:0] data, logic [3:0] blank,
                                 logic [3:0] blink, logic [3:0] bright, logic [3:0] esel,
                                 logic [6:0] edisp, logic efd);
        vec_t v;
        v.pos = pos; v.ld = ld; v.data = data; v.blank = blank; v.blink = blink;
        v.bright = bright; v.exp_sel = esel; v.exp_disp = edisp; v.exp_fd = efd;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto_pos(input int p);
        while (cyc < p) step();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s pos=%0d: got %0h, expected %0h", name, cyc - 1, got, exp);
        end else begin
            $display("ok   %s pos=%0d: %0h", name, cyc - 1, got);
        end
    endtask

    initial begin
        int cnt[4];
        int exp_cnt[4];
        int bad_disp, bad_fd, bad_s0, p;
        logic [3:0] onehot;
        logic [3:0] sel_at1, sel_at33;

        vecs[0]  = mkv(200, 1, PAT_A, 0, 0, 15, 4'b1011, 7'h7F, 0);
        vecs[1]  = mkv(256, 0, 0, 0, 0, 15, 4'b1111, 7'h7F, 0);
        vecs[2]  = mkv(257, 0, 0, 0, 0, 15, 4'b1110, 7'h40, 0);
        vecs[3]  = mkv(287, 0, 0, 0, 0, 15, 4'b1110, 7'h40, 0);
        vecs[4]  = mkv(288, 0, 0, 0, 0, 15, 4'b1111, 7'h7F, 0);
        vecs[5]  = mkv(289, 0, 0, 0, 0, 15, 4'b1101, 7'h79, 0);
        vecs[6]  = mkv(321, 0, 0, 0, 0, 15, 4'b1011, 7'h24, 0);
        vecs[7]  = mkv(353, 0, 0, 0, 0, 15, 4'b0111, 7'h30, 0);
        vecs[8]  = mkv(385, 0, 0, 0, 0, 0,  4'b1110, 7'h40, 0);
        vecs[9]  = mkv(386, 0, 0, 0, 0, 0,  4'b1111, 7'h7F, 0);
        vecs[10] = mkv(431, 0, 0, 0, 0, 7,  4'b1101, 7'h79, 0);
        vecs[11] = mkv(432, 0, 0, 0, 0, 7,  4'b1111, 7'h7F, 0);
        vecs[12] = mkv(479, 0, 0, 0, 0, 15, 4'b1011, 7'h24, 0);
        vecs[13] = mkv(481, 0, 0, 0, 0, 15, 4'b0111, 7'h30, 0);
        vecs[14] = mkv(577, 1, PAT_B, 0, 0, 15, 4'b1011, 7'h24, 0);
        vecs[15] = mkv(600, 1, PAT_C, 0, 0, 15, 4'b1011, 7'h24, 0);
        vecs[16] = mkv(609, 0, 0, 0, 0, 15, 4'b0111, 7'h30, 0);
        vecs[17] = mkv(641, 0, 0, 0, 0, 15, 4'b1110, 7'h08, 0);
        vecs[18] = mkv(673, 0, 0, 0, 0, 15, 4'b1101, 7'h03, 0);
        vecs[19] = mkv(767, 1, PAT_D, 0, 0, 15, 4'b0111, 7'h01, 1);
        vecs[20] = mkv(768, 0, 0, 0, 0, 15, 4'b1111, 7'h7F, 0);
        vecs[21] = mkv(769, 0, 0, 0, 0, 15, 4'b1110, 7'h1C, 0);
        vecs[22] = mkv(800, 1, PAT_D, 4'b0001, 4'b0100, 15, 4'b1111, 7'h7F, 0);
        vecs[23] = mkv(897, 0, 0, 0, 0, 15, 4'b1111, 7'h7F, 0);
        vecs[24] = mkv(929, 0, 0, 0, 0, 15, 4'b1101, 7'h2A, 0);
        vecs[25] = mkv(961, 0, 0, 0, 0, 15, 4'b1111, 7'h7F, 0);
        vecs[26] = mkv(993, 0, 0, 0, 0, 15, 4'b0111, 7'h4D, 0);
        vecs[27] = mkv(1025, 0, 0, 0, 0, 15, 4'b1111, 7'h7F, 0);
        vecs[28] = mkv(1089, 0, 0, 0, 0, 15, 4'b1011, 7'h3B, 0);
        vecs[29] = mkv(1217, 0, 0, 0, 0, 15, 4'b1011, 7'h3B, 0);
        vecs[30] = mkv(1345, 0, 0, 0, 0, 15, 4'b1111, 7'h7F, 0);
        vecs[31] = mkv(1420, 1, PAT_E, 0, 0, 15, 4'b1111, 7'h7F, 0);
        vecs[32] = mkv(1449, 0, 0, 0, 0, 15, 4'b1101, 7'h2A, 0);
        exp_cnt = '{31, 1, 15, 15};
        cnt = '{0, 0, 0, 0};

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_sel", 32'(selector), 32'hF);
        check("rst_disp", 32'(displayout), 32'h7F);
        check("rst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        cyc = 0;

        // Idle frames: dark patterns, frame_done cadence, on-time per brightness
        bad_disp = 0; bad_fd = 0; bad_s0 = 0;
        while (cyc < 192) begin
            p = cyc;
            brightness = (p < 32) ? 4'd15 : (p < 64) ? 4'd0 : 4'd7;
            step();
            if (displayout !== 7'h7F) bad_disp++;
            if (frame_done !== ((p % 128) == 127)) bad_fd++;
            if ((p % 32) == 0 && selector !== 4'hF) bad_s0++;
            onehot = 4'b0001 << (p / 32);
            if (p < 128 && selector === ~onehot) cnt[p / 32]++;
        end
        check("idle_disp_errs", 32'(bad_disp), 0);
        check("idle_fd_errs", 32'(bad_fd), 0);
        check("idle_slot0_errs", 32'(bad_s0), 0);
        for (int d = 0; d < 4; d++)
            check($sformatf("ontime_digit%0d", d), 32'(cnt[d]), 32'(exp_cnt[d]));

        // Table-driven scan, load, brightness and blink vectors
        for (int i = 0; i < 33; i++) begin
            goto_pos(vecs[i].pos);
            brightness = vecs[i].bright;
            load = vecs[i].ld;
            if (vecs[i].ld) begin
                digits_in = vecs[i].data;
                blank_mask = vecs[i].blank;
                blink_mask = vecs[i].blink;
            end
            step();
            load = 1'b0;
            check($sformatf("v%0d_sel", i), 32'(selector), 32'(vecs[i].exp_sel));
            check($sformatf("v%0d_disp", i), 32'(displayout), 32'(vecs[i].exp_disp));
            check($sformatf("v%0d_fd", i), 32'(frame_done), 32'(vecs[i].exp_fd));
        end

        // Reset mid-slot while a load is pending
        goto_pos(1450);
        rst_n = 1'b0;
        step();
        check("midrst_sel", 32'(selector), 32'hF);
        check("midrst_disp", 32'(displayout), 32'h7F);
        check("midrst_fd", 32'(frame_done), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
        brightness = 4'd15;
        bad_disp = 0; bad_fd = 0;
        sel_at1 = 4'hF; sel_at33 = 4'hF;
        while (cyc < 256) begin
            p = cyc;
            step();
            if (displayout !== 7'h7F) bad_disp++;
            if (frame_done !== ((p % 128) == 127)) bad_fd++;
            if (p == 1) sel_at1 = selector;
            if (p == 33) sel_at33 = selector;
        end
        check("post_rst_disp_errs", 32'(bad_disp), 0);
        check("post_rst_fd_errs", 32'(bad_fd), 0);
        check("post_rst_digit0", 32'(sel_at1), 32'hE);
        check("post_rst_digit1", 32'(sel_at33), 32'hD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Parametrised multiplexed seven-segment scan driver for N common-anode digits. It is the generalised successor of the fixed 8-digit display path. Game subsystems (menu, score, obstacle field, hero) write a full frame of segment patterns. The block latches frames tear-free at scan boundaries, time-multiplexes the selector lines, and adds per-digit blanking, blink, brightness PWM and an anti-ghosting guard.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
SEG_W, 7, segment bits per digit
REFRESH_DIV, 50000, clk cycles per digit slot; must be a multiple of 16 and >= 32
BLINK_DIV, 64, full scan frames per blink half-period (>= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
digits_in  in  NUM_DIGITS*SEG_W  segment patterns, active-low; digit 0 occupies bits [SEG_W-1:0]
blank_mask  in  NUM_DIGITS  1 = digit always dark
blink_mask  in  NUM_DIGITS  1 = digit dark during blink phase 1
brightness  in  4  0 = dimmest, 15 = full on-time
load  in  1  one-cycle strobe: capture digits_in/blank_mask/blink_mask
displayout  out  SEG_W  segment drive, active-low
selector  out  NUM_DIGITS  digit enable, active-low (one-cold or all-ones)
frame_done  out  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Clock and reset: clk is the only clock. rst_n is synchronous and active-low.
- Reset values (rst_n=0 sampled on a clk edge):
  - slot_cnt=0, digit_idx=0, blink_phase=0, blink_cnt=0.
  - Active and pending frames are all-ones (dark); active blank/blink masks are 0; pending_valid=0.
  - Outputs: selector = all ones, displayout = all ones, frame_done = 0.
  - Reset mid-frame discards any pending load.
- Counters:
  - slot_cnt runs 0..REFRESH_DIV-1, then wraps and digit_idx increments.
  - digit_idx wraps from NUM_DIGITS-1 to 0.
  - Frame boundary (FB) = the cycle where slot_cnt=REFRESH_DIV-1 and digit_idx=NUM_DIGITS-1.
- Loading:
  - load=1 copies the inputs into the pending registers and sets pending_valid.
  - A later load before FB overwrites pending (last load wins).
  - At FB: if load=1 in that same cycle, the active registers take the inputs directly. Otherwise, if pending_valid=1, they take the pending registers. pending_valid clears.
  - The active frame never changes mid-frame. New data is first visible in slot 0 of the next frame.
- Blink:
  - blink_cnt counts FBs 0..BLINK_DIV-1.
  - On the FB where blink_cnt=BLINK_DIV-1, blink_cnt wraps and blink_phase toggles.
- Digit lit condition, for digit d = digit_idx, all of the following hold:
  - slot_cnt != 0 (1-cycle ghost guard at the start of every slot);
  - slot_cnt < (brightness+1)*(REFRESH_DIV/16);
  - blank_mask_active[d] = 0;
  - NOT (blink_phase=1 AND blink_mask_active[d]=1).
- Output drive:
  - When lit: selector bit d = 0 and all other selector bits = 1; displayout = active pattern of digit d.
  - When not lit: selector = all ones and displayout = all ones.
- Outputs are registered, with 1-cycle latency from the counter state that produces them. This applies to both displayout and selector. brightness is sampled live, not latched.
- frame_done is registered and asserts for exactly one cycle, in the cycle after FB.
- Counter widths are $clog2-sized from the parameters. No arithmetic overflow is permitted in the on-time compare; use a width of at least clog2(REFRESH_DIV)+1.

Test Plan:
(Bench parameters: NUM_DIGITS=4, SEG_W=7, REFRESH_DIV=32, BLINK_DIV=2.)
- Reset/idle: hold rst_n=0 for 3 cycles, then release with no load -> selector=4'b1111 and displayout=7'h7F continuously; frame_done pulses every 128 cycles.
- Scan order and latency: load digits 7'h40,7'h79,7'h24,7'h30 with brightness=15 -> from the next frame, digit d has selector=~(1<<d) for 31 of every 32 cycles; the first cycle of each slot is dark; the digit order is 0,1,2,3.
- Tear-free load: pulse load with new patterns at slot 1 of digit 2, then again with a second set before FB -> the current frame keeps the old data; the next frame shows only the second set; a load exactly on FB shows immediately in slot 0.
- Brightness: brightness=0 -> lit for slot_cnt 1 only (1 cycle per slot); brightness=7 -> lit for slot_cnt 1..15 (15 cycles); brightness=15 -> 31 cycles.
- Blank/blink: blank_mask=4'b0001 and blink_mask=4'b0100 -> digit 0 is never lit; digit 2 is dark in frames 2-3, 6-7, … and lit in frames 0-1, 4-5; digits 1 and 3 are unaffected.
- Reset mid-operation: assert rst_n=0 mid-slot with a load pending -> outputs go dark on the next edge; after release, the counters restart at digit 0 and the pending data never appears.
